// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and the MEM stage.
// Runs one transaction at a time. Misaligned accesses fault without touching the port.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic [31:0]       IF_DATA,
  output logic              IF_DONE,
  output logic              IF_FAULT,
  output logic              V_IF_STALL,
  input  logic              MEM_REQ,
  input  logic              MEM_WE,
  input  logic [1:0]        MEM_SIZE,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_WDATA,
  output logic [DATA_W-1:0] MEM_RDATA,
  output logic              MEM_DONE,
  output logic              MEM_FAULT,
  output logic              V_MEM_STALL,
  output logic              PORT_V,
  output logic              PORT_WE,
  output logic [1:0]        PORT_SIZE,
  output logic [ADDR_W-1:0] PORT_ADDR,
  output logic [DATA_W-1:0] PORT_WDATA,
  input  logic [DATA_W-1:0] PORT_RDATA,
  input  logic              PORT_READY
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  logic [1:0]        r_state;
  logic              r_owner;
  logic [CNT_W-1:0]  r_starve;
  logic              r_fault;
  logic [31:0]       r_if_data;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_port_we;
  logic [1:0]        r_port_size;
  logic [ADDR_W-1:0] r_port_addr;
  logic [DATA_W-1:0] r_port_wdata;

  logic w_grant_mem;
  logic w_grant_if;
  logic w_mem_mis;
  logic w_if_mis;

  // MEM wins a tie until IF has been passed over STARVE_LIMIT times in a row.
  assign w_grant_mem = MEM_REQ && (!IF_REQ || (r_starve < LIMIT));
  assign w_grant_if  = IF_REQ && !w_grant_mem;
  assign w_if_mis    = |IF_ADDR[1:0];

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_mem_mis = 1'b0;
    case (MEM_SIZE)
      2'b01:   w_mem_mis = MEM_ADDR[0];
      2'b10:   w_mem_mis = |MEM_ADDR[1:0];
      2'b11:   w_mem_mis = |MEM_ADDR[2:0];
      default: w_mem_mis = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_IF;
      r_starve     <= '0;
      r_fault      <= 1'b0;
      r_if_data    <= '0;
      r_mem_rdata  <= '0;
      r_port_we    <= 1'b0;
      r_port_size  <= 2'b00;
      r_port_addr  <= '0;
      r_port_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_mem) begin
            r_owner <= OWN_MEM;
            if (IF_REQ) r_starve <= r_starve + CNT_W'(1);
            if (w_mem_mis) begin
              r_state     <= S_RESP;
              r_fault     <= 1'b1;
              r_mem_rdata <= '0;
            end else begin
              r_state      <= S_BUSY;
              r_fault      <= 1'b0;
              r_port_we    <= MEM_WE;
              r_port_size  <= MEM_SIZE;
              r_port_addr  <= MEM_ADDR;
              r_port_wdata <= MEM_WDATA;
            end
          end else if (w_grant_if) begin
            r_owner  <= OWN_IF;
            r_starve <= '0;
            if (w_if_mis) begin
              r_state   <= S_RESP;
              r_fault   <= 1'b1;
              r_if_data <= '0;
            end else begin
              r_state      <= S_BUSY;
              r_fault      <= 1'b0;
              r_port_we    <= 1'b0;
              r_port_size  <= 2'b10;
              r_port_addr  <= IF_ADDR;
              r_port_wdata <= '0;
            end
          end
        end
        S_BUSY: begin
          if (PORT_READY) begin
            r_state <= S_RESP;
            if (r_owner == OWN_IF) r_if_data <= PORT_RDATA[31:0];
            else                   r_mem_rdata <= r_port_we ? '0 : PORT_RDATA;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign IF_DONE     = (r_state == S_RESP) && (r_owner == OWN_IF);
  assign MEM_DONE    = (r_state == S_RESP) && (r_owner == OWN_MEM);
  assign IF_FAULT    = IF_DONE && r_fault;
  assign MEM_FAULT   = MEM_DONE && r_fault;
  assign V_IF_STALL  = IF_REQ && !IF_DONE;
  assign V_MEM_STALL = MEM_REQ && !MEM_DONE;

  assign IF_DATA     = r_if_data;
  assign MEM_RDATA   = r_mem_rdata;
  assign PORT_V      = (r_state == S_BUSY);
  assign PORT_WE     = r_port_we;
  assign PORT_SIZE   = r_port_size;
  assign PORT_ADDR   = r_port_addr;
  assign PORT_WDATA  = r_port_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the port is driven by hand, one cycle at a time.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IF_REQ;
  logic [63:0] IF_ADDR;
  logic [31:0] IF_DATA;
  logic        IF_DONE, IF_FAULT, V_IF_STALL;
  logic        MEM_REQ, MEM_WE;
  logic [1:0]  MEM_SIZE;
  logic [63:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic        MEM_DONE, MEM_FAULT, V_MEM_STALL;
  logic        PORT_V, PORT_WE;
  logic [1:0]  PORT_SIZE;
  logic [63:0] PORT_ADDR, PORT_WDATA, PORT_RDATA;
  logic        PORT_READY;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_DATA(IF_DATA), .IF_DONE(IF_DONE),
    .IF_FAULT(IF_FAULT), .V_IF_STALL(V_IF_STALL),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_SIZE(MEM_SIZE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_DONE(MEM_DONE),
    .MEM_FAULT(MEM_FAULT), .V_MEM_STALL(V_MEM_STALL),
    .PORT_V(PORT_V), .PORT_WE(PORT_WE), .PORT_SIZE(PORT_SIZE), .PORT_ADDR(PORT_ADDR),
    .PORT_WDATA(PORT_WDATA), .PORT_RDATA(PORT_RDATA), .PORT_READY(PORT_READY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1ns after the rising edge, before inputs are changed.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mem_req(input logic we, input logic [1:0] size, input logic [63:0] addr,
                         input logic [63:0] wdata);
    MEM_REQ = 1'b1; MEM_WE = we; MEM_SIZE = size; MEM_ADDR = addr; MEM_WDATA = wdata;
  endtask

  int n;
  logic exp_mem [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    RESET = 1'b1; IF_REQ = 1'b0; IF_ADDR = '0; MEM_REQ = 1'b0; MEM_WE = 1'b0;
    MEM_SIZE = 2'b00; MEM_ADDR = '0; MEM_WDATA = '0; PORT_RDATA = '0; PORT_READY = 1'b0;
    #12;
    check("rst_port_v", PORT_V, 0);
    check("rst_port_addr", PORT_ADDR, 0);
    check("rst_mem_done", MEM_DONE, 0);
    check("rst_if_done", IF_DONE, 0);
    @(negedge CLK);
    RESET = 1'b0;
    tick();

    // MEM-only 64-bit load, port ready in its second BUSY cycle
    mem_req(1'b0, 2'b11, 64'h100, 64'h0);
    tick();
    check("ld_port_v1", PORT_V, 1);
    check("ld_port_addr", PORT_ADDR, 64'h100);
    check("ld_port_size", PORT_SIZE, 2'b11);
    check("ld_port_we", PORT_WE, 0);
    check("ld_stall_busy", V_MEM_STALL, 1);
    tick();
    check("ld_port_v2", PORT_V, 1);
    check("ld_done_early", MEM_DONE, 0);
    PORT_READY = 1'b1; PORT_RDATA = 64'hDEADBEEF_CAFEF00D;
    tick();
    PORT_READY = 1'b0;
    check("ld_done", MEM_DONE, 1);
    check("ld_rdata", MEM_RDATA, 64'hDEADBEEF_CAFEF00D);
    check("ld_fault", MEM_FAULT, 0);
    check("ld_port_v_resp", PORT_V, 0);
    check("ld_stall_done", V_MEM_STALL, 0);
    MEM_REQ = 1'b0;
    tick();
    check("ld_done_pulse", MEM_DONE, 0);

    // Both requesting continuously: MEM x4, then IF, then MEM
    mem_req(1'b0, 2'b11, 64'h300, 64'h0);
    IF_REQ = 1'b1; IF_ADDR = 64'h200; PORT_RDATA = 64'h1111_2222_3333_4444;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      tick();
      check("starve_excl", IF_DONE & MEM_DONE, 0);
      if (MEM_DONE || IF_DONE) begin
        check($sformatf("starve_order%0d", n), MEM_DONE, exp_mem[n]);
        if (IF_DONE) check("starve_if_data", IF_DATA, 64'h3333_4444);
        n++;
        if (n == 6) begin MEM_REQ = 1'b0; IF_REQ = 1'b0; end
      end
      PORT_READY = PORT_V;
    end
    check("starve_count", n, 6);
    PORT_READY = 1'b0;
    tick();

    // Misaligned doubleword store faults without touching the port
    mem_req(1'b1, 2'b11, 64'h104, 64'h55);
    tick();
    check("mis_mem_done", MEM_DONE, 1);
    check("mis_mem_fault", MEM_FAULT, 1);
    check("mis_mem_port_v", PORT_V, 0);
    check("mis_mem_rdata", MEM_RDATA, 0);
    MEM_REQ = 1'b0;
    tick();
    check("mis_mem_idle_v", PORT_V, 0);
    IF_REQ = 1'b1; IF_ADDR = 64'h6;
    tick();
    check("mis_if_done", IF_DONE, 1);
    check("mis_if_fault", IF_FAULT, 1);
    check("mis_if_data", IF_DATA, 0);
    check("mis_if_port_v", PORT_V, 0);
    IF_REQ = 1'b0;
    tick();

    // Aligned halfword store at an odd-halfword boundary; store returns zero data
    mem_req(1'b1, 2'b01, 64'h102, 64'hABCD);
    tick();
    check("st_port_v", PORT_V, 1);
    check("st_port_we", PORT_WE, 1);
    check("st_port_wdata", PORT_WDATA, 64'hABCD);
    PORT_READY = 1'b1; PORT_RDATA = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    PORT_READY = 1'b0; MEM_REQ = 1'b0;
    check("st_done", MEM_DONE, 1);
    check("st_fault", MEM_FAULT, 0);
    check("st_rdata", MEM_RDATA, 0);
    tick();

    // Aligned fetch returns the low word
    IF_REQ = 1'b1; IF_ADDR = 64'h200;
    tick();
    check("if_port_v", PORT_V, 1);
    check("if_port_we", PORT_WE, 0);
    check("if_port_size", PORT_SIZE, 2'b10);
    check("if_port_addr", PORT_ADDR, 64'h200);
    PORT_READY = 1'b1; PORT_RDATA = 64'h1234_5678_0000_0013;
    tick();
    PORT_READY = 1'b0;
    check("if_done", IF_DONE, 1);
    check("if_data", IF_DATA, 64'h13);
    check("if_stall", V_IF_STALL, 0);
    IF_REQ = 1'b0;
    tick();

    // Asynchronous reset in the middle of BUSY
    mem_req(1'b0, 2'b11, 64'h180, 64'h0);
    tick();
    check("rb_port_v", PORT_V, 1);
    #2 RESET = 1'b1;
    #1;
    check("rb_port_v_rst", PORT_V, 0);
    check("rb_port_addr_rst", PORT_ADDR, 0);
    check("rb_port_size_rst", PORT_SIZE, 0);
    check("rb_if_data_rst", IF_DATA, 0);
    check("rb_mem_done_rst", MEM_DONE, 0);
    @(negedge CLK);
    RESET = 1'b0;
    tick();
    check("rb_port_v_again", PORT_V, 1);
    PORT_READY = 1'b1; PORT_RDATA = 64'h0BAD_F00D_0000_0001;
    tick();
    PORT_READY = 1'b0;
    check("rb_done", MEM_DONE, 1);
    check("rb_rdata", MEM_RDATA, 64'h0BAD_F00D_0000_0001);
    MEM_REQ = 1'b0;
    tick();

    // MEM drops its request mid-BUSY while IF becomes pending
    mem_req(1'b0, 2'b10, 64'h40, 64'h0);
    tick();
    MEM_REQ = 1'b0; IF_REQ = 1'b1; IF_ADDR = 64'h204;
    tick();
    check("drop_port_v", PORT_V, 1);
    check("drop_port_addr", PORT_ADDR, 64'h40);
    PORT_READY = 1'b1; PORT_RDATA = 64'h0000_0000_AAAA_5555;
    tick();
    PORT_READY = 1'b0;
    check("drop_mem_done", MEM_DONE, 1);
    check("drop_mem_rdata", MEM_RDATA, 64'hAAAA_5555);
    check("drop_if_done", IF_DONE, 0);
    check("drop_if_stall", V_IF_STALL, 1);
    PORT_READY = 1'b1; PORT_RDATA = 64'h77;
    tick();
    check("drop_idle_v", PORT_V, 0);
    check("drop_idle_done", MEM_DONE | IF_DONE, 0);
    PORT_READY = 1'b0;
    tick();
    check("drop_if_grant_v", PORT_V, 1);
    check("drop_if_grant_addr", PORT_ADDR, 64'h204);
    PORT_READY = 1'b1; PORT_RDATA = 64'h0000_0000_0000_0093;
    tick();
    PORT_READY = 1'b0;
    check("drop_if_done2", IF_DONE, 1);
    check("drop_if_data", IF_DATA, 64'h93);
    IF_REQ = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
